uart_rx_ctrl: RTL and testbench

Sequencer for the uart_rx bit datapath. It synchronises the raw RX pin and detects start bits. It generates the per-bit center_tick pulses that advance uart_rx, then collects each completed byte and its framing status. Good bytes are buffered in a small first-word-fall-through FIFO with a valid/ready consumer handshake; bad frames are counted and dropped.

---
 rtl/uart_rx_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: RX synchroniser, start detect, bit-centre strobes for uart_rx, and a FWFT byte FIFO.
// Build option UART_RX_GLITCH_FILTER_EN adds a 3-sample majority filter in front of rx_sync_out.
module uart_rx_ctrl #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_pin,
  output logic       rx_sync_out,
  output logic       center_tick,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_frame_error,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  input  logic       clr_status,
  output logic       busy,
  output logic       overflow,
  output logic [7:0] frame_err_count
);

  localparam int unsigned TICKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned HALF_BIT      = TICKS_PER_BIT / 2;
  localparam int unsigned CNT_W         = $clog2(TICKS_PER_BIT);
  localparam int unsigned PTR_W         = $clog2(FIFO_DEPTH);
  localparam int unsigned FILL_W        = PTR_W + 1;

  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  BIT_LOAD  = CNT_W'(TICKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LOAD = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0]  WIN_LOAD  = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FIFO_DEPTH);

  logic sync_1, sync_2, sync_prev, fall_edge;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= rx_pin;
      sync_2 <= sync_1;
    end
  end

`ifdef UART_RX_GLITCH_FILTER_EN
  // The vote spans the newest three samples so the filter costs only one extra cycle.
  logic sync_3, vote, filt_q;

  assign vote = (sync_1 & sync_2) | (sync_1 & sync_3) | (sync_2 & sync_3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_3 <= 1'b1;
      filt_q <= 1'b1;
    end else begin
      sync_3 <= sync_2;
      filt_q <= vote;
    end
  end

  assign rx_sync_out = filt_q;
`else
  assign rx_sync_out = sync_2;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_prev <= 1'b1;
    else          sync_prev <= rx_sync_out;
  end

  assign fall_edge = sync_prev & ~rx_sync_out;

  // state  | meaning
  // IDLE   | line idle, waiting for a falling edge
  // START  | half-bit wait, then confirm the start bit is still low
  // DATA   | one centre strobe per bit period for the 8 data bits
  // STOP   | one more bit period, strobe the stop bit
  // RESULT | two-cycle window to collect uart_rx's verdict
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    RESULT = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] tick_cnt, tick_nxt;
  logic [2:0]       bit_cnt, bit_nxt;
  logic             tc;
  logic             push_req, err_inc;

  assign tc = (tick_cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    case (state)
      IDLE: begin
        if (fall_edge) begin
          state_nxt = START;
          tick_nxt  = HALF_LOAD;
        end
      end
      START: begin
        if (!tc) begin
          tick_nxt = tick_cnt - CNT_ONE;
        end else if (!rx_sync_out) begin
          state_nxt = DATA;
          tick_nxt  = BIT_LOAD;
          bit_nxt   = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      DATA: begin
        if (!tc) begin
          tick_nxt = tick_cnt - CNT_ONE;
        end else begin
          tick_nxt = BIT_LOAD;
          bit_nxt  = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (!tc) begin
          tick_nxt = tick_cnt - CNT_ONE;
        end else begin
          state_nxt = RESULT;
          tick_nxt  = WIN_LOAD;
        end
      end
      RESULT: begin
        if (rx_valid || rx_frame_error || tc) state_nxt = IDLE;
        else                                  tick_nxt  = tick_cnt - CNT_ONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A missing verdict at the end of the window is treated as a bad frame.
  always_comb begin
    center_tick = 1'b0;
    push_req    = 1'b0;
    err_inc     = 1'b0;
    busy        = (state != IDLE);
    case (state)
      START:      center_tick = tc & ~rx_sync_out;
      DATA, STOP: center_tick = tc;
      RESULT: begin
        if (rx_frame_error)  err_inc  = 1'b1;
        else if (rx_valid)   push_req = 1'b1;
        else if (tc)         err_inc  = 1'b1;
      end
      default: ;
    endcase
  end

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FILL_W-1:0] fill;
  logic              full, pop, do_push;

  assign full       = (fill == FILL_FULL);
  assign byte_valid = (fill != '0);
  assign pop        = byte_valid & byte_ready;
  assign do_push    = push_req & (~full | pop);
  assign byte_data  = byte_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, pop})
        2'b10:   fill <= fill + FILL_ONE;
        2'b01:   fill <= fill - FILL_ONE;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= rx_data;
  end

  // A set or increment in the same cycle as clr_status takes priority over the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow        <= 1'b0;
      frame_err_count <= 8'h00;
    end else begin
      if (push_req && full && !pop) overflow <= 1'b1;
      else if (clr_status)          overflow <= 1'b0;

      if (err_inc) begin
        if (clr_status)                    frame_err_count <= 8'd1;
        else if (frame_err_count != 8'hFF) frame_err_count <= frame_err_count + 8'd1;
      end else if (clr_status) begin
        frame_err_count <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus random frames against a queue-based model.
// A small behavioural uart_rx answers the centre strobes so the byte path can be checked end to end.
module tb_uart_rx_ctrl;

  localparam int CLK_HZ = 1_300_000;
  localparam int BAUD   = 100_000;
  localparam int DEPTH  = 4;
  localparam int TPB    = CLK_HZ / BAUD;
  localparam int HALF   = TPB / 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_pin = 1'b1;
  logic       rx_sync_out, center_tick;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0, rx_frame_error = 1'b0;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready = 1'b0;
  logic       clr_status = 1'b0;
  logic       busy, overflow;
  logic [7:0] frame_err_count;

  uart_rx_ctrl #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .rx_pin(rx_pin), .rx_sync_out(rx_sync_out),
    .center_tick(center_tick), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_frame_error(rx_frame_error), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .clr_status(clr_status), .busy(busy),
    .overflow(overflow), .frame_err_count(frame_err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int tick_q[$];
  int fall_q[$];
  int exp_q[$];
  int exp_err = 0;
  int exp_ovf = 0;
  int resp_mode = 0;
  bit clr_on_resp = 1'b0;
  int clr_req = 0;
  int clr_done = 0;
  int ready_mode = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", tag, got, got, exp, exp, cyc);
    end
  endtask

  // Behavioural uart_rx: tick 1 is the start bit, ticks 2..9 data LSB first, tick 10 the stop bit.
  initial begin
    int n_tick;
    int delay;
    logic [7:0] shreg;
    logic stop_s;
    n_tick = 0; delay = -1; shreg = 8'h00; stop_s = 1'b1;
    forever begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_frame_error = 1'b0;
      clr_status = 1'b0;
      if (!reset_n) begin
        n_tick = 0;
        delay = -1;
      end else begin
        if (delay == 0) begin
          if (resp_mode != 2) begin
            if (stop_s) rx_valid = 1'b1;
            else        rx_frame_error = 1'b1;
          end
          if (clr_on_resp) clr_status = 1'b1;
          delay = -1;
        end else if (delay > 0) begin
          delay--;
        end
        if (center_tick) begin
          n_tick++;
          if (n_tick >= 2 && n_tick <= 9) shreg = {rx_sync_out, shreg[7:1]};
          if (n_tick == 10) begin
            stop_s = rx_sync_out;
            rx_data = shreg;
            n_tick = 0;
            delay = (resp_mode == 1) ? 1 : 0;
          end
        end
        if (clr_req != clr_done) begin
          clr_status = 1'b1;
          clr_done++;
        end
      end
    end
  end

  // Consumer and event log: byte_ready is chosen first, so the pop decision matches the next edge.
  initial begin
    bit prev_sync;
    prev_sync = 1'b1;
    forever begin
      @(negedge clk);
      if (center_tick) tick_q.push_back(cyc);
      if (prev_sync && !rx_sync_out) fall_q.push_back(cyc);
      prev_sync = rx_sync_out;
      case (ready_mode)
        0:       byte_ready = 1'b0;
        1:       byte_ready = 1'b1;
        default: byte_ready = 1'($urandom_range(0, 1));
      endcase
      if (reset_n && byte_valid && byte_ready)
        check("pop_data", byte_data, (exp_q.size() != 0) ? exp_q.pop_front() : -1);
    end
  end

  task automatic drive_bit(input logic b);
    rx_pin = b;
    repeat (TPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int hold,
                            input int mode, input bit clr_c);
    int t0;
    bit good;
    t0 = tick_q.size();
    good = stop && (mode != 2);
    if (good) begin
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(int'(d));
        if (clr_c) exp_ovf = 0;
      end else begin
        exp_ovf = 1;
      end
      if (clr_c) exp_err = 0;
    end else begin
      exp_err = clr_c ? 1 : ((exp_err < 255) ? exp_err + 1 : 255);
      if (clr_c) exp_ovf = 0;
    end
    resp_mode = mode;
    clr_on_resp = clr_c;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
    if (!stop) begin
      repeat (hold) @(posedge clk);
      #1;
    end
    rx_pin = 1'b1;
    repeat (2 * TPB) @(posedge clk);
    clr_on_resp = 1'b0;
    @(negedge clk);
    check("frame_ticks", tick_q.size() - t0, 10);
    check("frame_busy", busy, 0);
    check("frame_err_count", frame_err_count, exp_err);
    check("frame_overflow", overflow, exp_ovf);
    if (ready_mode == 1) begin
      check("frame_drained", exp_q.size(), 0);
      check("frame_valid_low", byte_valid, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, f0, fcyc;
    logic [7:0] d;
    logic st;

    reset_n = 1'b0;
    rx_pin = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_sync", rx_sync_out, 1);
    check("rst_tick", center_tick, 0);
    check("rst_valid", byte_valid, 0);
    check("rst_data", byte_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    check("rst_errcnt", frame_err_count, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2 * TPB) @(posedge clk);
    #1;

    // 0x55 with tick timing relative to the synchronised falling edge
    t0 = tick_q.size();
    f0 = fall_q.size();
    send_frame(8'h55, 1'b1, 0, 0, 1'b0);
    if (tick_q.size() >= t0 + 10 && fall_q.size() > f0) begin
      check("t55_first_tick", tick_q[t0] - fall_q[f0], HALF);
      for (int i = 1; i < 10; i++) check("t55_tick_gap", tick_q[t0 + i] - tick_q[t0 + i - 1], TPB);
    end else begin
      check("t55_tick_log", tick_q.size() - t0, 10);
    end

    // short low pulse: false start, busy drops right after the half-bit check
    t0 = tick_q.size();
    f0 = fall_q.size();
    @(posedge clk); #1 rx_pin = 1'b0;
    repeat (HALF - 2) @(posedge clk);
    #1 rx_pin = 1'b1;
    for (int k = 0; k < 10 && fall_q.size() == f0; k++) @(negedge clk);
    check("fs_fall_seen", fall_q.size() - f0, 1);
    if (fall_q.size() > f0) begin
      fcyc = fall_q[f0];
      while (cyc < fcyc + HALF) @(negedge clk);
      check("fs_busy_at_half", busy, 1);
      @(negedge clk);
      check("fs_busy_after", busy, 0);
    end
    repeat (3 * TPB) @(negedge clk);
    check("fs_no_ticks", tick_q.size() - t0, 0);
    check("fs_fifo_empty", byte_valid, 0);

    // bad stop with the line held low afterwards, then a good frame
    send_frame(8'hC1, 1'b0, 3 * TPB, 0, 1'b0);
    send_frame(8'h3C, 1'b1, 0, 0, 1'b0);
    send_frame(8'h12, 1'b1, 0, 2, 1'b0);
    send_frame(8'h99, 1'b0, 0, 0, 1'b1);
    send_frame(8'h77, 1'b1, 0, 1, 1'b0);

    // overflow with a stalled consumer, then drain and clear
    ready_mode = 0;
    @(negedge clk);
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 0, 0, 1'b0);
    check("ovf_head_valid", byte_valid, 1);
    check("ovf_head_data", byte_data, 8'h01);
    send_frame(8'h06, 1'b1, 0, 0, 1'b1);
    ready_mode = 1;
    for (int k = 0; k < 20 && byte_valid; k++) @(negedge clk);
    check("ovf_drained", exp_q.size(), 0);
    check("ovf_valid_low", byte_valid, 0);
    clr_req++;
    repeat (3) @(negedge clk);
    exp_ovf = 0;
    exp_err = 0;
    check("clr_ovf", overflow, exp_ovf);
    check("clr_errcnt", frame_err_count, exp_err);

    // random frames, verdict timing and consumer back-pressure
    ready_mode = 2;
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 3) != 0);
      send_frame(d, st, $urandom_range(0, 2 * TPB), $urandom_range(0, 2), ($urandom_range(0, 4) == 0));
    end
    ready_mode = 1;
    repeat (10) @(negedge clk);
    check("rand_drained", exp_q.size(), 0);
    check("rand_valid_low", byte_valid, 0);

    // frame error counter saturation
    for (int n = 0; n < 260; n++) send_frame(8'($urandom_range(0, 255)), 1'b0, 0, 0, 1'b0);
    check("sat_errcnt", frame_err_count, 255);

    // reset after the third centre strobe of a frame
    t0 = tick_q.size();
    @(posedge clk); #1 rx_pin = 1'b0;
    for (int k = 0; k < 4 * TPB && tick_q.size() < t0 + 3; k++) @(negedge clk);
    check("mid_three_ticks", tick_q.size() - t0, 3);
    reset_n = 1'b0;
    rx_pin = 1'b1;
    exp_q.delete();
    exp_err = 0;
    exp_ovf = 0;
    repeat (3) @(negedge clk);
    check("mid_busy", busy, 0);
    check("mid_valid", byte_valid, 0);
    check("mid_tick", center_tick, 0);
    check("mid_sync", rx_sync_out, 1);
    check("mid_errcnt", frame_err_count, exp_err);
    check("mid_ovf", overflow, exp_ovf);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2 * TPB) @(posedge clk);
    #1;
    send_frame(8'hA5, 1'b1, 0, 0, 1'b0);

    // single-cycle low glitch on an idle line never reaches a centre strobe
    t0 = tick_q.size();
    f0 = fall_q.size();
    @(posedge clk); #1 rx_pin = 1'b0;
    @(posedge clk); #1 rx_pin = 1'b1;
    repeat (3 * TPB) @(negedge clk);
    check("glitch_no_tick", tick_q.size() - t0, 0);
    check("glitch_busy", busy, 0);
`ifdef UART_RX_GLITCH_FILTER_EN
    check("glitch_no_fall", fall_q.size() - f0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
